// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the step-5 exception sequencer: cause codes, FSM states, defaults.
// Optional irq masking is enabled with EXC_IRQ_MASK_EN (see exc_ctrl.sv).
package exc_ctrl_pkg;

  localparam logic [2:0] EXC_IRQ     = 3'b000;
  localparam logic [2:0] EXC_OVF     = 3'b001;
  localparam logic [2:0] EXC_ILLOP   = 3'b010;
  localparam logic [2:0] EXC_UNALIGN = 3'b011;
  localparam logic [2:0] EXC_NONE    = 3'b100;

  localparam logic [15:0] HANDLER_ADDR_DEFAULT = 16'h0040;
  localparam logic [15:0] MIN_EPC_DEFAULT      = 16'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT,
    ST_HANDLER,
    ST_RETURN
  } exc_state_e;

endpackage

// File: rtl/exc_ctrl_take_logic.sv
// Combinational take decision: sync exception vs external interrupt, and the cause to latch.
module exc_ctrl_take_logic
  import exc_ctrl_pkg::*;
#(
  parameter logic [15:0] MIN_EPC = MIN_EPC_DEFAULT
) (
  input  logic        step4_valid,
  input  logic [15:0] step4_pc,
  input  logic [2:0]  step4_cause,
  input  logic        ext_irq,
  input  logic [15:0] last_epc,
  input  logic        irq_mask,
  output logic        sync_take,
  output logic        irq_take,
  output logic [2:0]  take_cause
);

  logic pc_ok;

  always_comb begin
    pc_ok      = step4_valid && (step4_pc >= MIN_EPC);
    // A cause of EXC_IRQ is exempt from the anti-livelock last_epc filter.
    sync_take  = pc_ok && (step4_cause != EXC_NONE) &&
                 ((step4_cause == EXC_IRQ) || (step4_pc != last_epc));
    irq_take   = pc_ok && ext_irq && !irq_mask;
    take_cause = sync_take ? step4_cause : EXC_IRQ;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Step-5 exception/interrupt sequencer: take, flush, redirect to handler, and eret return.
// Define EXC_IRQ_MASK_EN to add a software-writable external interrupt mask.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [15:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
  parameter logic [15:0] MIN_EPC      = MIN_EPC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step4_valid,
  input  logic [15:0] step4_pc,
  input  logic [2:0]  step4_cause,
  input  logic        ext_irq,
  input  logic        eret,
  output logic        flush,
  output logic        pc_redirect,
  output logic [15:0] pc_target,
  output logic [15:0] epc_reg,
  output logic [2:0]  cause_reg,
  output logic        in_handler,
  output logic        irq_ack
`ifdef EXC_IRQ_MASK_EN
  ,
  input  logic        irq_mask_we,
  input  logic        irq_mask_wd,
  output logic        irq_mask
`endif
);

  exc_state_e  state, state_nx;
  logic [15:0] last_epc;
  logic        sync_take, irq_take, take_idle, mask_in;
  logic [2:0]  take_cause;

  exc_ctrl_take_logic #(.MIN_EPC(MIN_EPC)) u_take (
    .step4_valid (step4_valid),
    .step4_pc    (step4_pc),
    .step4_cause (step4_cause),
    .ext_irq     (ext_irq),
    .last_epc    (last_epc),
    .irq_mask    (mask_in),
    .sync_take   (sync_take),
    .irq_take    (irq_take),
    .take_cause  (take_cause)
  );

  assign take_idle = (state == ST_IDLE) && (sync_take || irq_take);

`ifdef EXC_IRQ_MASK_EN
  logic irq_mask_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      irq_mask_r <= 1'b1;
    else if (take_idle && !sync_take)
      irq_mask_r <= 1'b1;
    else if (irq_mask_we)
      irq_mask_r <= irq_mask_wd;
  end

  assign irq_mask = irq_mask_r;
  assign mask_in  = irq_mask_r;
`else
  assign mask_in = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:     if (take_idle) state_nx = ST_FLUSH;
      ST_FLUSH:    state_nx = ST_REDIRECT;
      ST_REDIRECT: state_nx = ST_HANDLER;
      ST_HANDLER:  if (eret && step4_valid) state_nx = ST_RETURN;
      ST_RETURN:   state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    flush       = 1'b0;
    pc_redirect = 1'b0;
    in_handler  = 1'b0;
    unique case (state)
      ST_FLUSH:    flush = 1'b1;
      ST_REDIRECT: begin flush = 1'b1; pc_redirect = 1'b1; end
      ST_HANDLER:  in_handler = 1'b1;
      ST_RETURN:   begin flush = 1'b1; pc_redirect = 1'b1; in_handler = 1'b1; end
      default:     ;
    endcase
  end

  // pc_target is loaded one cycle ahead so it is stable while pc_redirect is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc_target <= '0;
      epc_reg   <= '0;
      cause_reg <= EXC_NONE;
      last_epc  <= '1;
      irq_ack   <= 1'b0;
    end else begin
      state   <= state_nx;
      irq_ack <= take_idle && !sync_take;
      if (take_idle) begin
        epc_reg   <= step4_pc;
        cause_reg <= take_cause;
        last_epc  <= step4_pc;
      end
      if (state == ST_FLUSH)
        pc_target <= HANDLER_ADDR;
      else if (state == ST_HANDLER && eret && step4_valid)
        pc_target <= epc_reg;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: directed vectors push expected outputs, a monitor pops and compares.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  typedef struct packed {
    logic        flush;
    logic        redir;
    logic [15:0] tgt;
    logic [15:0] epc;
    logic [2:0]  cause;
    logic        inh;
    logic        ack;
    logic        mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        step4_valid;
  logic [15:0] step4_pc;
  logic [2:0]  step4_cause;
  logic        ext_irq;
  logic        eret;
  logic        flush, pc_redirect, in_handler, irq_ack;
  logic [15:0] pc_target, epc_reg;
  logic [2:0]  cause_reg;
`ifdef EXC_IRQ_MASK_EN
  logic        irq_mask_we, irq_mask_wd, irq_mask;
  logic        pend_we = 1'b0;
  logic        pend_wd = 1'b0;
`endif

  exp_t sb[$];
  logic exp_mask;
  int   checks = 0;
  int   errors = 0;

  exc_ctrl #(.HANDLER_ADDR(16'h0040), .MIN_EPC(16'd5)) dut (
    .clk         (clk),
    .reset       (reset),
    .step4_valid (step4_valid),
    .step4_pc    (step4_pc),
    .step4_cause (step4_cause),
    .ext_irq     (ext_irq),
    .eret        (eret),
    .flush       (flush),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .epc_reg     (epc_reg),
    .cause_reg   (cause_reg),
    .in_handler  (in_handler),
    .irq_ack     (irq_ack)
`ifdef EXC_IRQ_MASK_EN
    ,
    .irq_mask_we (irq_mask_we),
    .irq_mask_wd (irq_mask_wd),
    .irq_mask    (irq_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("flush", {15'd0, flush}, {15'd0, e.flush});
    chk("pc_redirect", {15'd0, pc_redirect}, {15'd0, e.redir});
    chk("pc_target", pc_target, e.tgt);
    chk("epc_reg", epc_reg, e.epc);
    chk("cause_reg", {13'd0, cause_reg}, {13'd0, e.cause});
    chk("in_handler", {15'd0, in_handler}, {15'd0, e.inh});
    chk("irq_ack", {15'd0, irq_ack}, {15'd0, e.ack});
`ifdef EXC_IRQ_MASK_EN
    chk("irq_mask", {15'd0, irq_mask}, {15'd0, e.mask});
`endif
  endtask

  // Apply one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic iv, input logic [15:0] ipc, input logic [2:0] ic,
                     input logic iirq, input logic ieret,
                     input logic ef, input logic er, input logic [15:0] et,
                     input logic [15:0] ee, input logic [2:0] ec,
                     input logic eh, input logic ea);
    exp_t e;
    @(negedge clk);
    step4_valid = iv;
    step4_pc    = ipc;
    step4_cause = ic;
    ext_irq     = iirq;
    eret        = ieret;
`ifdef EXC_IRQ_MASK_EN
    irq_mask_we = pend_we;
    irq_mask_wd = pend_wd;
    pend_we     = 1'b0;
`endif
    e = '{flush: ef, redir: er, tgt: et, epc: ee, cause: ec, inh: eh, ack: ea, mask: exp_mask};
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_all(e);
      end
    end
  end

  localparam logic [2:0] N = EXC_NONE;

  initial begin : stim
    exp_t r;
    reset = 1'b1; step4_valid = 1'b0; step4_pc = '0; step4_cause = N;
    ext_irq = 1'b0; eret = 1'b0; exp_mask = 1'b1;
`ifdef EXC_IRQ_MASK_EN
    irq_mask_we = 1'b0; irq_mask_wd = 1'b0;
`endif
    cyc(0, 0, N, 0, 0,        0, 0, 16'h0, 16'd0, N, 0, 0);
    @(negedge clk) reset = 1'b0;

`ifdef EXC_IRQ_MASK_EN
    cyc(1, 40, N, 1, 0,       0, 0, 16'h0, 16'd0, N, 0, 0);
    pend_we = 1'b1; pend_wd = 1'b0; exp_mask = 1'b0;
    cyc(0, 0, N, 0, 0,        0, 0, 16'h0, 16'd0, N, 0, 0);
`endif
    // overflow at pc 20 -> flush, redirect, handler
    cyc(1, 20, EXC_OVF, 0, 0, 1, 0, 16'h0,  16'd20, EXC_OVF, 0, 0);
    cyc(0, 0, N, 0, 0,        1, 1, 16'h40, 16'd20, EXC_OVF, 0, 0);
    cyc(0, 0, N, 0, 0,        0, 0, 16'h40, 16'd20, EXC_OVF, 1, 0);
    cyc(0, 0, N, 0, 0,        0, 0, 16'h40, 16'd20, EXC_OVF, 1, 0);
    cyc(1, 50, N, 0, 1,       1, 1, 16'd20, 16'd20, EXC_OVF, 1, 0);
    cyc(0, 0, N, 0, 0,        0, 0, 16'd20, 16'd20, EXC_OVF, 0, 0);
    // boot-region fault, eret in IDLE, invalid slot, repeated EPC: none taken
    cyc(1, 3, EXC_ILLOP, 0, 0, 0, 0, 16'd20, 16'd20, EXC_OVF, 0, 0);
    cyc(1, 60, N, 0, 1,       0, 0, 16'd20, 16'd20, EXC_OVF, 0, 0);
    cyc(0, 30, EXC_OVF, 0, 0, 0, 0, 16'd20, 16'd20, EXC_OVF, 0, 0);
    cyc(1, 20, EXC_OVF, 0, 0, 0, 0, 16'd20, 16'd20, EXC_OVF, 0, 0);
    // new pc 24 taken; faults and irq during REDIRECT/HANDLER ignored
    cyc(1, 24, EXC_OVF, 0, 0, 1, 0, 16'd20, 16'd24, EXC_OVF, 0, 0);
    cyc(0, 0, N, 0, 0,        1, 1, 16'h40, 16'd24, EXC_OVF, 0, 0);
    cyc(1, 28, EXC_ILLOP, 0, 0, 0, 0, 16'h40, 16'd24, EXC_OVF, 1, 0);
    cyc(1, 32, EXC_UNALIGN, 1, 0, 0, 0, 16'h40, 16'd24, EXC_OVF, 1, 0);
    cyc(1, 36, N, 0, 1,       1, 1, 16'd24, 16'd24, EXC_OVF, 1, 0);
    cyc(0, 0, N, 0, 0,        0, 0, 16'd24, 16'd24, EXC_OVF, 0, 0);
    // sync beats irq; irq stays pending and is taken after return
    cyc(1, 30, EXC_OVF, 1, 0, 1, 0, 16'd24, 16'd30, EXC_OVF, 0, 0);
    cyc(0, 0, N, 1, 0,        1, 1, 16'h40, 16'd30, EXC_OVF, 0, 0);
    cyc(0, 0, N, 1, 0,        0, 0, 16'h40, 16'd30, EXC_OVF, 1, 0);
    cyc(1, 44, N, 1, 1,       1, 1, 16'd30, 16'd30, EXC_OVF, 1, 0);
    cyc(0, 0, N, 1, 0,        0, 0, 16'd30, 16'd30, EXC_OVF, 0, 0);
    exp_mask = 1'b1;
    cyc(1, 40, N, 1, 0,       1, 0, 16'd30, 16'd40, EXC_IRQ, 0, 1);
    cyc(0, 0, N, 0, 0,        1, 1, 16'h40, 16'd40, EXC_IRQ, 0, 0);
    cyc(0, 0, N, 0, 0,        0, 0, 16'h40, 16'd40, EXC_IRQ, 1, 0);
    cyc(1, 48, N, 0, 1,       1, 1, 16'd40, 16'd40, EXC_IRQ, 1, 0);
    cyc(0, 0, N, 0, 0,        0, 0, 16'd40, 16'd40, EXC_IRQ, 0, 0);
`ifdef EXC_IRQ_MASK_EN
    pend_we = 1'b1; pend_wd = 1'b0; exp_mask = 1'b0;
    cyc(0, 0, N, 0, 0,        0, 0, 16'd40, 16'd40, EXC_IRQ, 0, 0);
    exp_mask = 1'b1;
`endif
    // irq at the retained last_epc is still taken
    cyc(1, 40, N, 1, 0,       1, 0, 16'd40, 16'd40, EXC_IRQ, 0, 1);
    cyc(0, 0, N, 0, 0,        1, 1, 16'h40, 16'd40, EXC_IRQ, 0, 0);

    // asynchronous reset while in REDIRECT
    @(negedge clk);
    reset = 1'b1;
    exp_mask = 1'b1;
    #1;
    r = '{flush: 1'b0, redir: 1'b0, tgt: 16'h0, epc: 16'd0, cause: N, inh: 1'b0, ack: 1'b0, mask: 1'b1};
    chk_all(r);
    cyc(0, 0, N, 0, 0,        0, 0, 16'h0, 16'd0, N, 0, 0);
    @(negedge clk) reset = 1'b0;

    // MIN_EPC boundary
    cyc(1, 4, EXC_OVF, 0, 0,  0, 0, 16'h0, 16'd0, N, 0, 0);
    cyc(1, 5, EXC_UNALIGN, 0, 0, 1, 0, 16'h0, 16'd5, EXC_UNALIGN, 0, 0);
    cyc(0, 0, N, 0, 0,        1, 1, 16'h40, 16'd5, EXC_UNALIGN, 0, 0);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Sequencer for the step-5 exception path: samples step-4 cause and PC, decides whether to take an exception or external interrupt, latches EPC/cause, flushes the pipeline and redirects fetch to the handler.
- Restores the PC on eret.
- Sits beside fsm_step5 and feeds the PC-select mux in step 1 and the flush inputs of steps 1-4.

Parameters:
- HANDLER_ADDR, 16'h0040, fetch address of the common exception handler.
- MIN_EPC, 16'd5, exceptions with EPC below this (boot code) are never taken.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- step4_valid  input  1  step 4 holds a real (non-bubble) instruction.
- step4_pc  input  16  PC of the step-4 instruction (EPC candidate).
- step4_cause  input  3  cause code from step 4; `EXC_NONE when no exception.
- ext_irq  input  1  level-sensitive external interrupt request.
- eret  input  1  step-4 instruction is eret (valid only with step4_valid).
- flush  output  1  kill steps 1-4 this cycle.
- pc_redirect  output  1  step 1 loads pc_target next cycle.
- pc_target  output  16  redirect address.
- epc_reg  output  16  latched exception PC.
- cause_reg  output  3  latched cause.
- in_handler  output  1  handler currently executing.
- irq_ack  output  1  one-cycle pulse when ext_irq is taken.

Behaviour:
- Reset: state=IDLE. flush, pc_redirect, in_handler and irq_ack are 0. pc_target=0, epc_reg=0, cause_reg=`EXC_NONE, last_epc=16'hFFFF.
- Take condition, evaluated in IDLE only:
  - sync_take = step4_valid && step4_cause!=`EXC_NONE && step4_pc>=MIN_EPC && step4_pc!=last_epc.
  - irq_take = ext_irq && step4_valid && step4_pc>=MIN_EPC.
  - `EXC_IRQ (3'b000) bypasses the last_epc check.
- Priority: sync_take beats irq_take. ext_irq, being level, stays pending. Among sync causes, step4_cause is already single-valued; no further arbitration.
- IDLE -> FLUSH on take.
  - Same edge: epc_reg<=step4_pc, cause_reg<=cause (`EXC_IRQ for irq), last_epc<=step4_pc.
  - irq_ack=1 for the FLUSH cycle only, when the take was an irq.
- FLUSH (1 cycle): flush=1 -> REDIRECT.
- REDIRECT (1 cycle): pc_redirect=1, pc_target=HANDLER_ADDR, flush=1 -> HANDLER.
- Latency: take sampled at edge N; flush high in cycles N+1 and N+2; pc_redirect high in N+2; handler fetched at N+3.
- HANDLER: in_handler=1. All new takes are ignored; no nesting, irq left pending. eret && step4_valid -> RETURN.
- RETURN (1 cycle): pc_redirect=1, pc_target=epc_reg, flush=1, in_handler=1 -> IDLE. last_epc is retained, so the same faulting PC is not re-taken (anti-livelock); an irq at that PC is still taken.
- eret in IDLE/FLUSH/REDIRECT: ignored.
- step4_valid=0: no take, whatever the cause.
- Outputs are registered from state (Moore); pc_target holds its last value when pc_redirect=0.
- Reset mid-sequence: immediate return to reset values; any partial redirect is abandoned.

Optional Feature:
- EXC_IRQ_MASK_EN.
- When defined:
  - Adds input irq_mask_we (1) and irq_mask_wd (1), plus output irq_mask (1).
  - irq_mask resets to 1 (masked) and is written on irq_mask_we at the clock edge.
  - irq_take additionally requires !irq_mask.
  - Entering FLUSH from an irq take also forces irq_mask<=1; software unmasks.
- When undefined: no ports added; ext_irq is always enabled.

Decomposition:
- Shared include exc_defs.vh holds:
  - cause codes: `EXC_IRQ 3'b000, `EXC_OVF 3'b001, `EXC_ILLOP 3'b010, `EXC_UNALIGN 3'b011, `EXC_NONE 3'b100.
  - state encodings: IDLE, FLUSH, REDIRECT, HANDLER, RETURN.
  - the HANDLER_ADDR default.
- One sub-module is natural: exc_take_logic, combinational. It computes sync_take, irq_take and the selected cause from the step-4 inputs, last_epc and the mask. The FSM and registers stay in exc_ctrl.

Test Plan:
1. step4_pc=16'd20, cause=`EXC_OVF, valid=1 in IDLE -> cycle+1 flush=1; cycle+2 pc_redirect=1, pc_target=16'h0040; epc_reg=20, cause_reg=001; then in_handler=1.
2. step4_pc=16'd3, cause=`EXC_ILLOP -> no take: flush stays 0, epc_reg unchanged.
3. ext_irq=1 and cause=`EXC_OVF same cycle, pc=30 -> cause_reg=001, irq_ack=0. After eret, IDLE with ext_irq still high and pc=40 -> cause_reg=000, irq_ack pulses exactly 1 cycle.
4. In HANDLER, eret with valid=1 -> next cycle pc_redirect=1, pc_target=epc_reg, flush=1, then IDLE with in_handler=0. eret in IDLE -> no outputs change.
5. After returning from OVF at pc=20, OVF again at pc=20 -> not taken. OVF at pc=24 -> taken. New fault in HANDLER -> ignored.
6. reset asserted during REDIRECT -> same cycle pc_redirect=0, flush=0, epc_reg=0. With EXC_IRQ_MASK_EN, ext_irq=1 and irq_mask=1 -> no take until irq_mask_we/wd=0 is written.
